// File: rtl/alu16_pkg.sv
// Shared definitions for the 16-bit arithmetic sequencer.
//   alu16_op_e    : operation encoding presented on the op input
//   alu16_state_e : sequencer states
//   BYTE_ZERO / BYTE_ONES : constant adder operands
package alu16_pkg;

  typedef enum logic [1:0] {
    ALU16_ADD    = 2'd0,   // ADD HL,rr
    ALU16_ADDSPE = 2'd1,   // ADD SP,e (e signed 8-bit)
    ALU16_INC    = 2'd2,   // INC rr
    ALU16_DEC    = 2'd3    // DEC rr
  } alu16_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } alu16_state_e;

  localparam logic [7:0] BYTE_ZERO = 8'h00;
  localparam logic [7:0] BYTE_ONES = 8'hFF;

endpackage

// File: rtl/alu16_bsel.sv
// Combinational selection of the second adder operand and carry-in for one
// byte pass of a 16-bit operation.
//   op_i       : latched operation
//   hi_pass_i  : 0 = low-byte pass, 1 = high-byte pass
//   lo_c_i     : carry out of the low-byte pass (chained into the high pass)
//   opb_lo_i   : opb[7:0] (also the signed displacement e for ADDSPE)
//   opb_hi_i   : opb[15:8]
//   alu_b_o    : adder operand 2
//   alu_cin_o  : adder carry-in
module alu16_bsel
  import alu16_pkg::*;
(
  input  alu16_op_e  op_i,
  input  logic       hi_pass_i,
  input  logic       lo_c_i,
  input  logic [7:0] opb_lo_i,
  input  logic [7:0] opb_hi_i,
  output logic [7:0] alu_b_o,
  output logic       alu_cin_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    alu_b_o   = BYTE_ZERO;
    alu_cin_o = 1'b0;
    if (!hi_pass_i) begin
      unique case (op_i)
        ALU16_ADD:    alu_b_o   = opb_lo_i;
        ALU16_ADDSPE: alu_b_o   = opb_lo_i;
        ALU16_INC:    alu_cin_o = 1'b1;       // +1 through the carry-in
        ALU16_DEC:    alu_b_o   = BYTE_ONES;  // -1 as two's complement 0xFFFF
      endcase
    end else begin
      alu_cin_o = lo_c_i;
      unique case (op_i)
        ALU16_ADD:    alu_b_o = opb_hi_i;
        // Sign extension of e into the upper byte.
        ALU16_ADDSPE: alu_b_o = opb_lo_i[7] ? BYTE_ONES : BYTE_ZERO;
        ALU16_INC:    alu_b_o = BYTE_ZERO;
        ALU16_DEC:    alu_b_o = BYTE_ONES;
      endcase
    end
  end

endmodule

// File: rtl/alu16_seq.sv
// Sequencer that performs 16-bit ADD HL,rr / ADD SP,e / INC rr / DEC rr on a
// shared 8-bit adder: a low-byte pass, then a high-byte pass with the carry
// chained, then a one-cycle DONE presenting the result and flag updates.
//   CLK, RESET        : clock, synchronous active-high reset
//   start, op, opa, opb : request and operands (latched on acceptance)
//   busy, done, res   : status and 16-bit result (res valid while done)
//   alu_a/alu_b/alu_cin : drive to the external 8-bit adder
//   alu_res/alu_cout/alu_hout : combinational adder results
//   flag_* / wren_*   : flag values and write enables, nonzero only in DONE
module alu16_seq
  import alu16_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic        busy,
  output logic        done,
  output logic [15:0] res,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_cin,
  input  logic [7:0]  alu_res,
  input  logic        alu_cout,
  input  logic        alu_hout,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_h,
  output logic        flag_c,
  output logic        wren_z,
  output logic        wren_n,
  output logic        wren_h,
  output logic        wren_c
);

  alu16_state_e state_q, state_d;
  alu16_op_e    op_q;
  logic [15:0]  opa_q, opb_q;
  logic [7:0]   lo_res_q, hi_res_q;
  logic         lo_c_q, lo_h_q, hi_c_q, hi_h_q;

  logic         accept;
  logic [7:0]   bsel_b;
  logic         bsel_cin;

  // Requests are only heard once the previous operation is out of the passes.
  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_LOW;
      S_LOW:  state_d = S_HIGH;
      S_HIGH: state_d = S_DONE;
      S_DONE: state_d = accept ? S_LOW : S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RESET) begin
      state_q  <= S_IDLE;
      op_q     <= ALU16_ADD;
      opa_q    <= '0;
      opb_q    <= '0;
      lo_res_q <= '0;
      lo_c_q   <= 1'b0;
      lo_h_q   <= 1'b0;
      hi_res_q <= '0;
      hi_c_q   <= 1'b0;
      hi_h_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= alu16_op_e'(op);
        opa_q <= opa;
        opb_q <= opb;
      end
      if (state_q == S_LOW) begin
        lo_res_q <= alu_res;
        lo_c_q   <= alu_cout;
        lo_h_q   <= alu_hout;
      end
      if (state_q == S_HIGH) begin
        hi_res_q <= alu_res;
        hi_c_q   <= alu_cout;
        hi_h_q   <= alu_hout;
      end
    end
  end

  alu16_bsel u_bsel (
    .op_i      (op_q),
    .hi_pass_i (state_q == S_HIGH),
    .lo_c_i    (lo_c_q),
    .opb_lo_i  (opb_q[7:0]),
    .opb_hi_i  (opb_q[15:8]),
    .alu_b_o   (bsel_b),
    .alu_cin_o (bsel_cin)
  );

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    res     = '0;
    alu_a   = BYTE_ZERO;
    alu_b   = BYTE_ZERO;
    alu_cin = 1'b0;
    flag_z  = 1'b0;
    flag_n  = 1'b0;
    flag_h  = 1'b0;
    flag_c  = 1'b0;
    wren_z  = 1'b0;
    wren_n  = 1'b0;
    wren_h  = 1'b0;
    wren_c  = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_LOW: begin
        busy    = 1'b1;
        alu_a   = opa_q[7:0];
        alu_b   = bsel_b;
        alu_cin = bsel_cin;
      end
      S_HIGH: begin
        busy    = 1'b1;
        alu_a   = opa_q[15:8];
        alu_b   = bsel_b;
        alu_cin = bsel_cin;
      end
      S_DONE: begin
        done = 1'b1;
        res  = {hi_res_q, lo_res_q};
        unique case (op_q)
          // 16-bit add: flags come from bit 11 / bit 15 carries (high pass).
          ALU16_ADD: begin
            flag_h = hi_h_q;
            flag_c = hi_c_q;
            wren_n = 1'b1;
            wren_h = 1'b1;
            wren_c = 1'b1;
          end
          // SP+e: flags come from bit 3 / bit 7 carries (low pass); Z cleared.
          ALU16_ADDSPE: begin
            flag_h = lo_h_q;
            flag_c = lo_c_q;
            wren_z = 1'b1;
            wren_n = 1'b1;
            wren_h = 1'b1;
            wren_c = 1'b1;
          end
          ALU16_INC, ALU16_DEC: ;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_alu16_seq.sv
// Self-checking bench for alu16_seq with a behavioural 8-bit adder and a
// 16-bit arithmetic reference model.
module tb_alu16_seq;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [15:0] opa = '0, opb = '0;
  logic        busy, done, alu_cin, alu_cout, alu_hout;
  logic [15:0] res;
  logic [7:0]  alu_a, alu_b, alu_res;
  logic        flag_z, flag_n, flag_h, flag_c, wren_z, wren_n, wren_h, wren_c;

  int n_checks = 0;
  int n_pass   = 0;

  alu16_seq dut (
    .CLK(CLK), .RESET(RESET), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .res(res),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_cout(alu_cout), .alu_hout(alu_hout),
    .flag_z(flag_z), .flag_n(flag_n), .flag_h(flag_h), .flag_c(flag_c),
    .wren_z(wren_z), .wren_n(wren_n), .wren_h(wren_h), .wren_c(wren_c)
  );

  always #5 CLK = ~CLK;

  // Behavioural 8-bit adder: a + b + cin, with carries out of bit 3 and 7.
  always_comb begin
    int s, s4;
    s  = int'(alu_a) + int'(alu_b) + int'(alu_cin);
    s4 = int'(alu_a[3:0]) + int'(alu_b[3:0]) + int'(alu_cin);
    alu_res  = s[7:0];
    alu_cout = (s > 255);
    alu_hout = (s4 > 15);
  end

  logic [7:0] flags_obs;
  assign flags_obs = {flag_z, flag_n, flag_h, flag_c, wren_z, wren_n, wren_h, wren_c};

  // Reference: {res[15:0], Z,N,H,C, wZ,wN,wH,wC} from plain 16-bit arithmetic.
  function automatic logic [23:0] model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    int ai, bi, e, r;
    logic h, c;
    ai = int'(a);
    bi = int'(b);
    e  = int'($signed(b[7:0]));
    h  = 1'b0;
    c  = 1'b0;
    case (o)
      2'd0: begin
        r = ai + bi;
        h = ((ai % 4096) + (bi % 4096)) >= 4096;
        c = r >= 65536;
        return {r[15:0], 1'b0, 1'b0, h, c, 1'b0, 1'b1, 1'b1, 1'b1};
      end
      2'd1: begin
        r = ai + e;
        h = ((ai % 16) + (bi % 16)) >= 16;
        c = ((ai % 256) + (bi % 256)) >= 256;
        return {r[15:0], 1'b0, 1'b0, h, c, 4'b1111};
      end
      2'd2: begin r = ai + 1;     return {r[15:0], 8'h00}; end
      default: begin r = ai + 65535; return {r[15:0], 8'h00}; end
    endcase
  endfunction

  // Carry that the low-byte pass must produce (and hand to the high pass).
  function automatic logic lo_carry(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    case (o)
      2'd0, 2'd1: return (int'(a[7:0]) + int'(b[7:0])) >= 256;
      2'd2:       return a[7:0] == 8'hFF;
      default:    return a[7:0] != 8'h00;   // no borrow unless low byte is 0
    endcase
  endfunction

  // Present a request for exactly one rising edge; returns at the LOW-cycle negedge.
  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Count negedges until done (bounded); cyc = 0 if it never came.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      if (done === 1'b1) begin cyc = i; return; end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; start = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({busy, done, res, alu_a, alu_b, alu_cin, flags_obs} !== 43'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b res=%h a=%h b=%h cin=%b flags=%b, want all zero",
               busy, done, res, alu_a, alu_b, alu_cin, flags_obs);
    else n_pass++;
    RESET = 1'b0; start = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL reset_idle: got busy=%b done=%b want 00", busy, done);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [1:0]  vo [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
    logic [15:0] va [6] = '{16'h0FFF, 16'hFFFF, 16'hFFF8, 16'h0001, 16'hFFFF, 16'h0000};
    logic [15:0] vb [6] = '{16'h0001, 16'h0001, 16'hAB08, 16'h00FE, 16'h1234, 16'h5678};
    logic [23:0] exp;
    for (int i = 0; i < 6; i++) begin
      exp = model(vo[i], va[i], vb[i]);
      issue(vo[i], va[i], vb[i]);
      n_checks++;
      if ({busy, done} !== 2'b10) $display("FAIL dir%0d_low: got busy=%b done=%b want 10", i, busy, done);
      else n_pass++;
      @(negedge CLK);   // HIGH pass
      n_checks++;
      if ({busy, alu_a, alu_cin} !== {1'b1, va[i][15:8], lo_carry(vo[i], va[i], vb[i])})
        $display("FAIL dir%0d_high: got busy=%b a=%h cin=%b want 1 %h %b", i, busy, alu_a, alu_cin,
                 va[i][15:8], lo_carry(vo[i], va[i], vb[i]));
      else n_pass++;
      @(negedge CLK);   // DONE, start+3
      n_checks++;
      if ({done, busy, res, flags_obs} !== {2'b10, exp})
        $display("FAIL dir%0d_done: got done=%b busy=%b res=%h flags=%b want 1 0 %h %b", i, done, busy,
                 res, flags_obs, exp[23:8], exp[7:0]);
      else n_pass++;
      n_checks++;
      if ({alu_a, alu_b, alu_cin} !== 17'd0)
        $display("FAIL dir%0d_alu_in_done: got a=%h b=%h cin=%b want 0", i, alu_a, alu_b, alu_cin);
      else n_pass++;
      @(negedge CLK);
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [15:0] a, b;
    logic [23:0] exp;
    int cyc;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = 16'($urandom);
      b = 16'($urandom);
      exp = model(o, a, b);
      issue(o, a, b);
      wait_done(cyc);
      n_checks++;
      if (cyc != 2 || {res, flags_obs} !== exp)
        $display("FAIL rand%0d op=%0d a=%h b=%h: got cyc=%0d res=%h flags=%b want cyc=2 %h %b",
                 i, o, a, b, cyc, res, flags_obs, exp[23:8], exp[7:0]);
      else n_pass++;
      @(negedge CLK);
    end
  endtask

  task automatic test_ignored_start();
    logic [23:0] exp;
    int cyc;
    exp = model(2'd0, 16'h1234, 16'h0FCD);
    issue(2'd0, 16'h1234, 16'h0FCD);
    start = 1'b1; op = 2'd3; opa = 16'hDEAD; opb = 16'hBEEF;   // during LOW
    @(negedge CLK);
    start = 1'b0;
    wait_done(cyc);
    n_checks++;
    if (cyc != 1 || {res, flags_obs} !== exp)
      $display("FAIL ignored_start_result: got cyc=%0d res=%h flags=%b want 1 %h %b",
               cyc, res, flags_obs, exp[23:8], exp[7:0]);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL ignored_start_no_queue: got busy=%b done=%b want 00", busy, done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp1, exp2;
    int cyc;
    exp1 = model(2'd1, 16'h8000, 16'h0080);
    exp2 = model(2'd0, 16'h7FFF, 16'h8001);
    start = 1'b1; op = 2'd1; opa = 16'h8000; opb = 16'h0080;
    @(negedge CLK);
    op = 2'd0; opa = 16'h7FFF; opb = 16'h8001;   // start stays high
    wait_done(cyc);
    n_checks++;
    if (cyc != 2 || {res, flags_obs} !== exp1)
      $display("FAIL b2b_first: got cyc=%0d res=%h flags=%b want 2 %h %b", cyc, res, flags_obs, exp1[23:8], exp1[7:0]);
    else n_pass++;
    cyc = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      if (done === 1'b1) begin cyc = i; break; end
    end
    start = 1'b0;
    n_checks++;
    if (cyc != 3 || {res, flags_obs} !== exp2)
      $display("FAIL b2b_second: got gap=%0d res=%h flags=%b want 3 %h %b", cyc, res, flags_obs, exp2[23:8], exp2[7:0]);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL b2b_idle: got busy=%b done=%b want 00", busy, done);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [23:0] exp;
    int cyc;
    bit seen;
    issue(2'd0, 16'h00FF, 16'h0001);
    @(negedge CLK);   // HIGH
    RESET = 1'b1; start = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({busy, done, res, alu_a, alu_b, alu_cin, flags_obs} !== 43'd0)
      $display("FAIL reset_mid_outputs: got busy=%b done=%b res=%h a=%h b=%h cin=%b flags=%b want all zero",
               busy, done, res, alu_a, alu_b, alu_cin, flags_obs);
    else n_pass++;
    RESET = 1'b0; start = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL reset_mid_no_done: got activity after reset, want none");
    else n_pass++;
    exp = model(2'd3, 16'h0100, 16'h0000);
    issue(2'd3, 16'h0100, 16'h0000);
    wait_done(cyc);
    n_checks++;
    if (cyc != 2 || {res, flags_obs} !== exp)
      $display("FAIL reset_mid_restart: got cyc=%0d res=%h flags=%b want 2 %h %b", cyc, res, flags_obs, exp[23:8], exp[7:0]);
    else n_pass++;
    @(negedge CLK);
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
